// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing XOR checksum state.
package imem_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_W     = 8;
  localparam int HDR_W      = HDR_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;

  // A zero-length image or one that would not fit in memory is rejected.
  function automatic logic hdr_bad(input logic [HDR_W-1:0] n, input int aw);
    return (n == '0) || ({1'b0, n} > ((HDR_W+1)'(1) << aw));
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Packs four big-endian bytes into a 32-bit word; word_valid pulses for
// one cycle after the fourth byte is accepted.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [BYTE_W-1:0]            byte_in,
  input  logic [1:0]                   byte_cnt,
  input  logic                         accept,
  output logic [WORD_BYTES*BYTE_W-1:0] word,
  output logic                         word_valid
);

  logic [(WORD_BYTES-1)*BYTE_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (accept) begin
        shreg <= {shreg[(WORD_BYTES-2)*BYTE_W-1:0], byte_in};
        if (byte_cnt == 2'(WORD_BYTES-1)) begin
          word       <= {shreg, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed byte image, writes it into
// instruction memory and then releases the pipeline reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR byte).
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int CW = ADDR_WIDTH + 1;

  state_e            state;
  logic [BYTE_W-1:0] n_hi;
  logic [CW-1:0]     n_words;
  logic [CW-1:0]     word_idx;
  logic [1:0]        byte_cnt;
  logic              accept;
  logic              load_accept;
  logic              word_last;
  logic [HDR_W-1:0]  hdr_n;
  logic [31:0]       asm_word;
  logic              asm_valid;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
`endif

  assign accept      = rx_valid && rx_ready;
  assign load_accept = accept && (state == S_LOAD);
  assign word_last   = (byte_cnt == 2'(WORD_BYTES-1));
  assign hdr_n       = {n_hi, rx_data};

  byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (rx_data),
    .byte_cnt   (byte_cnt),
    .accept     (load_accept),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // The assembler's word register is the write-data register; the address is
  // captured on the same edge so both line up with the we pulse.
  assign imem_we    = asm_valid;
  assign imem_wdata = asm_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rx_ready     <= 1'b0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      imem_addr    <= '0;
      words_loaded <= '0;
      n_hi         <= '0;
      n_words      <= '0;
      word_idx     <= '0;
      byte_cnt     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      if (imem_we && (words_loaded != n_words))
        words_loaded <= words_loaded + CW'(1);

      case (state)
        S_IDLE: begin
          state    <= S_HDR_HI;
          rx_ready <= 1'b1;
        end

        S_HDR_HI: if (accept) begin
          n_hi  <= rx_data;
          state <= S_HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum  <= csum ^ rx_data;
`endif
        end

        S_HDR_LO: if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ rx_data;
`endif
          if (hdr_bad(hdr_n, ADDR_WIDTH)) begin
            state      <= S_ERROR;
            rx_ready   <= 1'b0;
            load_error <= 1'b1;
          end else begin
            n_words <= CW'(hdr_n);
            state   <= S_LOAD;
          end
        end

        S_LOAD: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum     <= csum ^ rx_data;
`endif
          if (word_last) begin
            imem_addr <= word_idx[ADDR_WIDTH-1:0];
            word_idx  <= word_idx + CW'(1);
            if (word_idx + CW'(1) == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DRAIN;
              rx_ready <= 1'b0;
`endif
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Words are already in memory on a mismatch; only release is withheld.
        S_CSUM: if (accept) begin
          rx_ready <= 1'b0;
          if (rx_data == csum) begin
            state <= S_DRAIN;
          end else begin
            state      <= S_ERROR;
            load_error <= 1'b1;
          end
        end
`endif

        S_DRAIN: begin
          state     <= S_DONE;
          cpu_reset <= 1'b0;
          load_done <= 1'b1;
        end

        S_DONE:  state <= S_DONE;
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, throttled input, header
// errors, optional checksum and reset mid-load.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [7:0]    img[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_load_error", 32'(load_error), 0);
    chk("rst_words_loaded", 32'(words_loaded), 0);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Byte is presented at a negedge and counted as accepted at the first
  // posedge where rx_ready is high.
  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("send_timeout", 32'(rx_ready), 1);
    @(posedge clk);
    if (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hFF;
    end
  endtask

  task automatic send_img(input bit gap);
    for (int i = 0; i < img.size(); i++)
      send(img[i], gap && (i != img.size() - 1));
  endtask

  // Called right after the posedge that accepted the final byte.
  task automatic check_release(input string tag, input logic [AW-1:0] la,
                               input logic [31:0] ld, input int nw);
    @(negedge clk);
    rx_valid = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk({tag, "_we"}, 32'(imem_we), 1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(la));
    chk({tag, "_wdata"}, imem_wdata, ld);
`endif
    chk({tag, "_cpu_reset_c1"}, 32'(cpu_reset), 1);
    @(negedge clk);
    chk({tag, "_cpu_reset_c2"}, 32'(cpu_reset), 0);
    chk({tag, "_load_done"}, 32'(load_done), 1);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_words_loaded"}, 32'(words_loaded), 32'(nw));
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(wr_addr[0]), 0);
      chk({tag, "_d0"}, wr_data[0], 32'h20080005);
      chk({tag, "_a1"}, 32'(wr_addr[1]), 1);
      chk({tag, "_d1"}, wr_data[1], 32'h8C090004);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Two-word image, rx_valid held high
    do_reset();
    @(negedge clk);
    chk("first_rx_ready", 32'(rx_ready), 1);
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(8'hAE);
`endif
    send_img(1'b0);
    check_release("img2", 8'd1, 32'h8C090004, 2);
    repeat (3) @(negedge clk);
    check_two_writes("img2");
    chk("img2_done_held", 32'(load_done), 1);

    // Same image, rx_valid toggled with junk data while invalid
    do_reset();
    send_img(1'b1);
    check_release("gap", 8'd1, 32'h8C090004, 2);
    repeat (3) @(negedge clk);
    check_two_writes("gap");

    // Zero-length header
    do_reset();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("hdr0_error", 32'(load_error), 1);
    chk("hdr0_cpu_reset", 32'(cpu_reset), 1);
    chk("hdr0_rx_ready", 32'(rx_ready), 0);
    repeat (6) @(negedge clk);
    chk("hdr0_nwr", 32'(wr_addr.size()), 0);
    chk("hdr0_done", 32'(load_done), 0);
    chk("hdr0_cpu_reset_held", 32'(cpu_reset), 1);

    // Header one past memory depth
    do_reset();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    @(negedge clk);
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    chk("hdrbig_error", 32'(load_error), 1);
    repeat (8) @(negedge clk);
    rx_valid = 1'b0;
    chk("hdrbig_nwr", 32'(wr_addr.size()), 0);
    chk("hdrbig_cpu_reset", 32'(cpu_reset), 1);

    // Largest legal header is accepted (moves to LOAD, no error)
    do_reset();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("hdrmax_no_error", 32'(load_error), 0);
    chk("hdrmax_rx_ready", 32'(rx_ready), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum
    do_reset();
    img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_img(1'b0);
    check_release("csum_ok", 8'd0, 32'h11223344, 1);

    // Bad checksum: word written, pipeline held
    do_reset();
    img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_img(1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("csum_bad_error", 32'(load_error), 1);
    chk("csum_bad_cpu_reset", 32'(cpu_reset), 1);
    repeat (3) @(negedge clk);
    chk("csum_bad_done", 32'(load_done), 0);
    chk("csum_bad_nwr", 32'(wr_addr.size()), 1);
    if (wr_addr.size() == 1) begin
      chk("csum_bad_a0", 32'(wr_addr[0]), 0);
      chk("csum_bad_d0", wr_data[0], 32'h11223344);
    end
`endif

    // Reset after 5 payload bytes, then a fresh one-word image
    do_reset();
    img = '{8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_img(1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("mid_partial_nwr", 32'(wr_addr.size()), 1);
    do_reset();
    img = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef IMEM_LOADER_CHECKSUM_EN
    img.push_back(8'h01);
`endif
    send_img(1'b0);
    check_release("mid_reload", 8'd0, 32'hAABBCCDD, 1);
    repeat (3) @(negedge clk);
    chk("mid_reload_nwr", 32'(wr_addr.size()), 1);
    if (wr_addr.size() == 1) begin
      chk("mid_reload_a0", 32'(wr_addr[0]), 0);
      chk("mid_reload_d0", wr_data[0], 32'hAABBCCDD);
    end
    chk("mid_reload_error", 32'(load_error), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
